prv_trap_ctrl: RTL and testbench
================================

# prv_trap_ctrl

Parametrised trap sequencer between the pipeline hazard unit and the privilege block. Collects N exception flags and M interrupt lines, selects one trap or an xRET by fixed priority, waits for the pipeline to drain, then issues a single redirect (`insert_pc`/`priv_pc`) and a one-cycle commit pulse carrying cause, EPC and bad address for the CSR file. It generalises the fixed exception/interrupt set of the current priv–pipeline link to configurable source counts, with optional vectored interrupt dispatch.

## Interface
Parameters:
- `NUM_EXC`, 12, exception sources; bit index = cause code and priority (0 highest)
- `NUM_INT`, 3, interrupt sources; bit index = interrupt cause code and priority (0 highest)
- `CAUSE_W`, 5, cause field width; must satisfy 2^CAUSE_W ≥ max(NUM_EXC, NUM_INT)

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1, clock
- `nRST` in 1, async active-low reset
- `exc_req` in NUM_EXC, exception flags from the hazard unit
- `exc_epc` in 32, PC of the faulting/interrupted instruction
- `exc_badaddr` in 32, faulting address/instruction
- `int_pend` in NUM_INT, level interrupt pending lines
- `int_en` in NUM_INT, per-source enables (xIE)
- `gie` in 1, global interrupt enable (xSTATUS.xIE)
- `ret` in 1, xRET retiring
- `pipe_clear` in 1, pipeline drained
- `xtvec` in 32, trap vector CSR
- `xepc_r` in 32, current xEPC CSR value
- `insert_pc` out 1, redirect strobe
- `priv_pc` out 32, redirect target
- `intr` out 1, latched trap is an interrupt
- `trap_commit` out 1, one-cycle CSR update strobe (traps only)
- `cause` out CAUSE_W, latched cause code
- `epc` out 32, latched EPC
- `badaddr` out 32, latched bad address (0 for interrupts)
- `busy` out 1, state ≠ IDLE

## Operation
- States: IDLE, DRAIN, INSERT.
- IDLE, priority: any `exc_req` > `ret` > enabled interrupt (`gie & |(int_pend & int_en)`).
  - Exception: latch lowest set index as `cause`, `intr`=0, `epc`=`exc_epc`, `badaddr`=`exc_badaddr`, kind=TRAP → DRAIN.
  - `ret`: kind=RET, target=`xepc_r` → DRAIN; cause/epc/badaddr unchanged.
  - Interrupt: lowest set index of `int_pend & int_en` as `cause`, `intr`=1, `epc`=`exc_epc`, `badaddr`=0 → DRAIN.
- Target computed and latched at selection: TRAP uses `{xtvec[31:2],2'b00}` (see Configuration); RET uses `xepc_r`.
- DRAIN: hold; all new `exc_req`/`ret`/interrupt changes ignored; latched trap is committed even if `int_pend` drops. → INSERT when `pipe_clear`=1.
- INSERT: `insert_pc`=1, `priv_pc`=target; `trap_commit`=1 iff kind=TRAP. Always → IDLE next cycle.
- Interrupt lines remain unmasked by the block; re-entry is prevented only by the CSR file clearing `gie` on `trap_commit`.

## Timing
- Reset: state IDLE; `insert_pc`, `trap_commit`, `intr`, `busy`=0; `priv_pc`, `epc`, `badaddr`=0; `cause`=0.
- All outputs registered. Request sampled at edge N → DRAIN from N; `pipe_clear` high at edge N+1 → INSERT cycle between N+1 and N+2. Minimum request-to-`insert_pc` latency 2 cycles; back-to-back traps ≥3 cycles apart.
- `insert_pc`/`trap_commit` are exactly one cycle wide.
- `pipe_clear` already high in IDLE has no effect; only sampled in DRAIN.
- Simultaneous `exc_req` and `ret`: exception wins, `ret` dropped.
- Reset asserted in DRAIN/INSERT: immediate return to IDLE, no strobe emitted.
- Cause index encoding: zero-extended to CAUSE_W.

## Configuration
- `TRAP_CTRL_VECTORED_EN` defined: for interrupts with `xtvec[1:0]`=2'b01, target = `{xtvec[31:2],2'b00}` + 4×`cause` (32-bit wrap); exceptions and `xtvec[1:0]`≠01 use base.
- Undefined: all traps target `{xtvec[31:2],2'b00}`; `xtvec[1:0]` ignored.

## Test plan
- `exc_req`=12'h004, `exc_epc`=0x100, `exc_badaddr`=0xDEAD, `xtvec`=0x8000; `pipe_clear` next cycle → `insert_pc` 2 cycles later, `priv_pc`=0x8000, `cause`=2, `intr`=0, `trap_commit`=1.
- `exc_req`=12'h00A with `ret`=1 and `int_pend`=3'b111 enabled → `cause`=1, TRAP; `ret` ignored.
- `int_pend`=3'b110, `int_en`=3'b100, `gie`=1, `xtvec`=0x8001 → with macro `priv_pc`=0x8008, `cause`=2, `intr`=1, `badaddr`=0; without macro `priv_pc`=0x8000.
- `ret`=1, `xepc_r`=0x240; `pipe_clear` held low 5 cycles → `busy`=1 throughout, then `insert_pc` with `priv_pc`=0x240, `trap_commit`=0.
- Interrupt latched, `int_pend` deasserted in DRAIN, `exc_req` pulsed in DRAIN → original interrupt still inserted, exception ignored.
- `nRST` low in DRAIN → outputs reset values, no `insert_pc`; `gie`=0 with `int_pend` set → no trap.

Source files
------------

// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl: trap sequencer between the hazard unit and the privilege block.
// It picks one exception, xRET or interrupt by fixed priority and waits for the
// pipeline to drain. It then issues a single one-cycle redirect, with a commit
// pulse for traps.
// Optional feature: define TRAP_CTRL_VECTORED_EN for vectored interrupt dispatch.
module prv_trap_ctrl #(
    parameter int unsigned NUM_EXC = 12,
    parameter int unsigned NUM_INT = 3,
    parameter int unsigned CAUSE_W = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NUM_EXC-1:0] exc_req,
    input  logic [31:0]        exc_epc,
    input  logic [31:0]        exc_badaddr,
    input  logic [NUM_INT-1:0] int_pend,
    input  logic [NUM_INT-1:0] int_en,
    input  logic               gie,
    input  logic               ret,
    input  logic               pipe_clear,
    input  logic [31:0]        xtvec,
    input  logic [31:0]        xepc_r,
    output logic               insert_pc,
    output logic [31:0]        priv_pc,
    output logic               intr,
    output logic               trap_commit,
    output logic [CAUSE_W-1:0] cause,
    output logic [31:0]        epc,
    output logic [31:0]        badaddr,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StDrain, StInsert} state_e;

    state_e               state_q;
    logic                 kind_ret_q;
    logic                 insert_pc_q;
    logic                 trap_commit_q;
    logic [31:0]          priv_pc_q;
    logic                 intr_q;
    logic [CAUSE_W-1:0]   cause_q;
    logic [31:0]          epc_q;
    logic [31:0]          badaddr_q;
    logic                 busy_q;

    logic [CAUSE_W-1:0]   exc_idx;
    logic [CAUSE_W-1:0]   int_idx;
    logic [NUM_INT-1:0]   int_masked;
    logic                 int_fire;
    logic [31:0]          tvec_base;
    logic [31:0]          int_tgt;

    // Priority encoders (lowest index wins) and redirect target selection.
    always_comb begin
        exc_idx = '0;
        for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
            if (exc_req[i]) exc_idx = CAUSE_W'(i);
        end
        int_masked = int_pend & int_en;
        int_fire   = gie & (|int_masked);
        int_idx    = '0;
        for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
            if (int_masked[i]) int_idx = CAUSE_W'(i);
        end
        // Mode bits are masked off; the base is always word aligned.
        tvec_base = xtvec & 32'hFFFF_FFFC;
`ifdef TRAP_CTRL_VECTORED_EN
        int_tgt = (xtvec[1:0] == 2'b01) ? tvec_base + (32'(int_idx) << 2) : tvec_base;
`else
        int_tgt = tvec_base;
`endif
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= StIdle;
            kind_ret_q    <= 1'b0;
            insert_pc_q   <= 1'b0;
            trap_commit_q <= 1'b0;
            priv_pc_q     <= '0;
            intr_q        <= 1'b0;
            cause_q       <= '0;
            epc_q         <= '0;
            badaddr_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    insert_pc_q   <= 1'b0;
                    trap_commit_q <= 1'b0;
                    if (|exc_req) begin
                        cause_q    <= exc_idx;
                        intr_q     <= 1'b0;
                        epc_q      <= exc_epc;
                        badaddr_q  <= exc_badaddr;
                        kind_ret_q <= 1'b0;
                        priv_pc_q  <= tvec_base;
                        busy_q     <= 1'b1;
                        state_q    <= StDrain;
                    end else if (ret) begin
                        // xRET leaves the trap record untouched.
                        kind_ret_q <= 1'b1;
                        priv_pc_q  <= xepc_r;
                        busy_q     <= 1'b1;
                        state_q    <= StDrain;
                    end else if (int_fire) begin
                        cause_q    <= int_idx;
                        intr_q     <= 1'b1;
                        epc_q      <= exc_epc;
                        badaddr_q  <= '0;
                        kind_ret_q <= 1'b0;
                        priv_pc_q  <= int_tgt;
                        busy_q     <= 1'b1;
                        state_q    <= StDrain;
                    end
                end
                StDrain: begin
                    // New requests are ignored until the latched one is issued.
                    if (pipe_clear) begin
                        insert_pc_q   <= 1'b1;
                        trap_commit_q <= ~kind_ret_q;
                        state_q       <= StInsert;
                    end
                end
                StInsert: begin
                    insert_pc_q   <= 1'b0;
                    trap_commit_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                default: begin
                    insert_pc_q   <= 1'b0;
                    trap_commit_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    assign insert_pc   = insert_pc_q;
    assign priv_pc     = priv_pc_q;
    assign intr        = intr_q;
    assign trap_commit = trap_commit_q;
    assign cause       = cause_q;
    assign epc         = epc_q;
    assign badaddr     = badaddr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Self-checking bench for prv_trap_ctrl: vector table, hand sequences, random vs model.
module tb_prv_trap_ctrl;

    logic        CLK;
    logic        nRST;
    logic [11:0] exc_req;
    logic [31:0] exc_epc;
    logic [31:0] exc_badaddr;
    logic [2:0]  int_pend;
    logic [2:0]  int_en;
    logic        gie;
    logic        ret;
    logic        pipe_clear;
    logic [31:0] xtvec;
    logic [31:0] xepc_r;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        intr;
    logic        trap_commit;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    prv_trap_ctrl #(.NUM_EXC(12), .NUM_INT(3), .CAUSE_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .exc_req(exc_req), .exc_epc(exc_epc),
        .exc_badaddr(exc_badaddr), .int_pend(int_pend), .int_en(int_en), .gie(gie),
        .ret(ret), .pipe_clear(pipe_clear), .xtvec(xtvec), .xepc_r(xepc_r),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr), .trap_commit(trap_commit),
        .cause(cause), .epc(epc), .badaddr(badaddr), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef TRAP_CTRL_VECTORED_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif
    localparam logic [31:0] ROW2_PC = VECTORED ? 32'h8008 : 32'h8000;

    typedef struct {
        logic [11:0] exc;
        logic        r;
        logic [2:0]  ip;
        logic [2:0]  ie;
        logic        g;
        logic [31:0] e_in;
        logic [31:0] b_in;
        logic [31:0] tv;
        logic [31:0] xe;
        logic        fire;
        logic        commit;
        logic [31:0] pc;
        logic [4:0]  cse;
        logic        it;
        logic [31:0] e_exp;
        logic [31:0] b_exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        exc_req  = '0;
        ret      = 1'b0;
        int_pend = '0;
        int_en   = '0;
        gie      = 1'b0;
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Request -> DRAIN, one cycle later pipe_clear -> INSERT, then back to IDLE.
    task automatic apply_vec(input vec_t v, input int idx);
        string s;
        exc_req = v.exc; ret = v.r; int_pend = v.ip; int_en = v.ie; gie = v.g;
        exc_epc = v.e_in; exc_badaddr = v.b_in; xtvec = v.tv; xepc_r = v.xe;
        pipe_clear = 1'b0;
        tick();
        s = $sformatf("vec%0d", idx);
        chk({s, " busy"}, 32'(busy), 32'(v.fire));
        chk({s, " no_early_insert"}, 32'(insert_pc), 32'd0);
        clear_inputs();
        pipe_clear = 1'b1;
        tick();
        chk({s, " insert_pc"}, 32'(insert_pc), 32'(v.fire));
        if (v.fire) begin
            chk({s, " trap_commit"}, 32'(trap_commit), 32'(v.commit));
            chk({s, " priv_pc"}, priv_pc, v.pc);
            chk({s, " cause"}, 32'(cause), 32'(v.cse));
            chk({s, " intr"}, 32'(intr), 32'(v.it));
            chk({s, " epc"}, epc, v.e_exp);
            chk({s, " badaddr"}, badaddr, v.b_exp);
        end
        pipe_clear = 1'b0;
        tick();
        chk({s, " insert_one_cycle"}, 32'(insert_pc), 32'd0);
        chk({s, " idle"}, 32'(busy), 32'd0);
    endtask

    // Random transactions against a behavioural model of the selection rules.
    task automatic random_phase(input int iters);
        logic [31:0] m_pc, m_epc, m_bad;
        int          m_cause;
        logic        m_intr, m_fire, m_commit;
        int          d, e;
        m_epc = 0; m_bad = 0; m_cause = 0; m_intr = 0; m_pc = 0;
        for (int it = 0; it < iters; it++) begin
            exc_req     = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'h000;
            ret         = ($urandom_range(0, 3) == 0);
            int_pend    = 3'($urandom);
            int_en      = 3'($urandom);
            gie         = 1'($urandom);
            exc_epc     = $urandom;
            exc_badaddr = $urandom;
            xtvec       = $urandom;
            xepc_r      = $urandom;
            pipe_clear  = 1'($urandom);
            m_fire = 1'b1; m_commit = 1'b1;
            e = lowest({20'd0, exc_req});
            if (e >= 0) begin
                m_cause = e; m_intr = 0; m_epc = exc_epc; m_bad = exc_badaddr;
                m_pc = xtvec - (xtvec % 4);
            end else if (ret) begin
                m_commit = 1'b0; m_pc = xepc_r;
            end else if (gie && (int_pend & int_en) != 0) begin
                m_cause = lowest({29'd0, int_pend & int_en});
                m_intr = 1; m_epc = exc_epc; m_bad = 0;
                m_pc = xtvec - (xtvec % 4);
                if (VECTORED && (xtvec % 4) == 1) m_pc = m_pc + 32'(4 * m_cause);
            end else begin
                m_fire = 1'b0;
            end
            tick();
            chk("rnd busy", 32'(busy), 32'(m_fire));
            chk("rnd no_insert_sel", 32'(insert_pc), 32'd0);
            if (m_fire) begin
                d = $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    exc_req = 12'($urandom); ret = 1'($urandom);
                    int_pend = 3'($urandom); gie = 1'($urandom);
                    pipe_clear = 1'b0;
                    tick();
                    chk("rnd drain_busy", 32'(busy), 32'd1);
                    chk("rnd drain_no_insert", 32'(insert_pc), 32'd0);
                end
                exc_req = 12'($urandom); ret = 1'($urandom);
                pipe_clear = 1'b1;
                tick();
                chk("rnd insert_pc", 32'(insert_pc), 32'd1);
                chk("rnd trap_commit", 32'(trap_commit), 32'(m_commit));
                chk("rnd priv_pc", priv_pc, m_pc);
                chk("rnd cause", 32'(cause), 32'(m_cause));
                chk("rnd intr", 32'(intr), 32'(m_intr));
                chk("rnd epc", epc, m_epc);
                chk("rnd badaddr", badaddr, m_bad);
                clear_inputs();
                pipe_clear = 1'($urandom);
                tick();
                chk("rnd back_idle", 32'(busy), 32'd0);
                chk("rnd insert_drop", 32'(insert_pc), 32'd0);
            end
            clear_inputs();
        end
    endtask

    initial begin
        tbl[0] = '{12'h004, 1'b0, 3'b000, 3'b000, 1'b0, 32'h100, 32'hDEAD, 32'h8000, 32'h0,
                   1'b1, 1'b1, 32'h8000, 5'd2, 1'b0, 32'h100, 32'hDEAD};
        tbl[1] = '{12'h00A, 1'b1, 3'b111, 3'b111, 1'b1, 32'h200, 32'hBEEF, 32'h8000, 32'h999,
                   1'b1, 1'b1, 32'h8000, 5'd1, 1'b0, 32'h200, 32'hBEEF};
        tbl[2] = '{12'h000, 1'b0, 3'b110, 3'b100, 1'b1, 32'h300, 32'h1234, 32'h8001, 32'h0,
                   1'b1, 1'b1, ROW2_PC, 5'd2, 1'b1, 32'h300, 32'h0};
        tbl[3] = '{12'h000, 1'b1, 3'b000, 3'b000, 1'b0, 32'h777, 32'h888, 32'h8001, 32'h240,
                   1'b1, 1'b0, 32'h240, 5'd2, 1'b1, 32'h300, 32'h0};
        tbl[4] = '{12'h000, 1'b0, 3'b111, 3'b111, 1'b0, 32'h0, 32'h0, 32'h8000, 32'h0,
                   1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{12'h800, 1'b0, 3'b111, 3'b111, 1'b1, 32'h400, 32'h55, 32'h9001, 32'h0,
                   1'b1, 1'b1, 32'h9000, 5'd11, 1'b0, 32'h400, 32'h55};
        tbl[6] = '{12'h000, 1'b0, 3'b011, 3'b011, 1'b1, 32'h500, 32'h66, 32'hA001, 32'h0,
                   1'b1, 1'b1, 32'hA000, 5'd0, 1'b1, 32'h500, 32'h0};
        tbl[7] = '{12'h000, 1'b0, 3'b100, 3'b011, 1'b1, 32'h0, 32'h0, 32'h8000, 32'h0,
                   1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0};

        nRST = 1'b0; clear_inputs(); pipe_clear = 1'b0;
        exc_epc = '0; exc_badaddr = '0; xtvec = '0; xepc_r = '0;
        tick();
        tick();
        chk("rst insert_pc", 32'(insert_pc), 32'd0);
        chk("rst trap_commit", 32'(trap_commit), 32'd0);
        chk("rst intr", 32'(intr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst priv_pc", priv_pc, 32'd0);
        chk("rst epc", epc, 32'd0);
        chk("rst badaddr", badaddr, 32'd0);
        chk("rst cause", 32'(cause), 32'd0);
        nRST = 1'b1;

        // pipe_clear in IDLE without a request does nothing.
        pipe_clear = 1'b1;
        tick();
        tick();
        chk("idle pipe_clear insert", 32'(insert_pc), 32'd0);
        chk("idle pipe_clear busy", 32'(busy), 32'd0);
        pipe_clear = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(tbl[i], i);

        // xRET with a long drain.
        ret = 1'b1; xepc_r = 32'h240;
        tick();
        ret = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("ret hold busy", 32'(busy), 32'd1);
            chk("ret hold no_insert", 32'(insert_pc), 32'd0);
        end
        pipe_clear = 1'b1;
        tick();
        chk("ret insert_pc", 32'(insert_pc), 32'd1);
        chk("ret priv_pc", priv_pc, 32'h240);
        chk("ret trap_commit", 32'(trap_commit), 32'd0);
        pipe_clear = 1'b0;
        tick();
        chk("ret insert_one_cycle", 32'(insert_pc), 32'd0);

        // Interrupt survives int_pend dropping; exception during DRAIN is ignored.
        int_pend = 3'b010; int_en = 3'b111; gie = 1'b1; xtvec = 32'hC000;
        exc_epc = 32'h600; exc_badaddr = 32'h77;
        tick();
        clear_inputs();
        exc_req = 12'h001; exc_epc = 32'h999; exc_badaddr = 32'h999;
        tick();
        exc_req = '0;
        pipe_clear = 1'b1;
        tick();
        chk("drain_int insert_pc", 32'(insert_pc), 32'd1);
        chk("drain_int intr", 32'(intr), 32'd1);
        chk("drain_int cause", 32'(cause), 32'd1);
        chk("drain_int epc", epc, 32'h600);
        chk("drain_int badaddr", badaddr, 32'd0);
        chk("drain_int commit", 32'(trap_commit), 32'd1);
        pipe_clear = 1'b0;
        tick();

        // Asynchronous reset while in DRAIN.
        exc_req = 12'h010; exc_epc = 32'hABC; exc_badaddr = 32'hDEF; xtvec = 32'h4000;
        tick();
        exc_req = '0;
        chk("rstdrain busy_before", 32'(busy), 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstdrain busy", 32'(busy), 32'd0);
        chk("rstdrain epc", epc, 32'd0);
        chk("rstdrain priv_pc", priv_pc, 32'd0);
        chk("rstdrain cause", 32'(cause), 32'd0);
        #2;
        nRST = 1'b1;
        pipe_clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstdrain no_insert", 32'(insert_pc), 32'd0);
            chk("rstdrain no_commit", 32'(trap_commit), 32'd0);
        end
        pipe_clear = 1'b0;

        // gie low masks all interrupts.
        int_pend = 3'b111; int_en = 3'b111; gie = 1'b0;
        tick();
        tick();
        chk("gie0 busy", 32'(busy), 32'd0);
        clear_inputs();

        // Restart from reset so the random model begins from known state.
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        random_phase(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
